latency_window_checker: RTL and testbench

Synthesizable multi-channel implication monitor: for each channel, every sampled trigger `a` must be followed by a response `b` between `MIN_LAT` and `MAX_LAT` clocks later. It is the hardware successor to the fixed `a |-> ##4 b` property check. It tracks up to `DEPTH` overlapping triggers per channel and reports pass, timeout, spurious and overflow events as registered pulses, saturating counters and a sticky error flag. It sits beside the DUT in simulation benches and in FPGA debug builds, where SVA is unavailable.

---
 rtl/latency_window_checker.sv | 189 ++++++++++++++++++
 tb/tb_latency_window_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latency_window_checker.sv
// latency_window_checker
// Multi-channel trigger/response latency monitor. Every trigger a_i[ch] must be
// answered by b_i[ch] between MIN_LAT and MAX_LAT edges later. Up to DEPTH
// outstanding triggers are tracked per channel as an age FIFO (oldest at slot 0).
// Events are reported as registered one-cycle pulses, saturating counters and a
// sticky error flag.
// Build option:
//   LWC_SPURIOUS_CHECK_EN - when defined, a response with no eligible trigger is
//                           reported on spur_o and counted as an error.
`timescale 1ns/1ps
module latency_window_checker #(
  parameter int CHANNELS = 2,
  parameter int MIN_LAT  = 4,
  parameter int MAX_LAT  = 4,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_i,
  input  logic [CHANNELS-1:0]       a_i,
  input  logic [CHANNELS-1:0]       b_i,
  output logic [CHANNELS-1:0]       pass_o,
  output logic [CHANNELS-1:0]       fail_o,
  output logic [CHANNELS-1:0]       spur_o,
  output logic [CHANNELS-1:0]       ovf_o,
  output logic [CHANNELS*CNT_W-1:0] pass_cnt_o,
  output logic [CHANNELS*CNT_W-1:0] fail_cnt_o,
  output logic                      err_o
);

  localparam int AW = $clog2(MAX_LAT + 1);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0]    MIN_AGE  = AW'(MIN_LAT);
  localparam logic [AW-1:0]    MAX_AGE  = AW'(MAX_LAT);
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CHANNELS-1:0] bad_evt;
  logic                err_q;
  logic                err_d;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [AW-1:0]    age_q [DEPTH];
    logic [AW-1:0]    age_d [DEPTH];
    logic [AW-1:0]    shift_src [DEPTH+1];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [CW-1:0]    cnt_rem;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             spur_q, spur_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W:0]   fail_sum;
    logic [1:0]       bad_inc;
    logic [AW-1:0]    oldest;
    logic             has_entry;
    logic             in_window;
    logic             hit;
    logic             timeout;
    logic             spur;
    logic             full;
    logic             pop;
    logic             push;
    logic             ovf;

    // Judge the oldest outstanding trigger, then decide push/drop for a_i.
    // An entry never ages past MAX_LAT (it is retired at MAX_LAT either way),
    // so only the lower window bound needs an explicit compare.
    always_comb begin
      oldest    = age_q[0];
      has_entry = (cnt_q != '0);
      in_window = (oldest >= MIN_AGE);
      hit       = !clr_i && b_i[ch] && has_entry && in_window;
      timeout   = !clr_i && !b_i[ch] && has_entry && (oldest == MAX_AGE);
`ifdef LWC_SPURIOUS_CHECK_EN
      spur      = !clr_i && b_i[ch] && (!has_entry || (oldest < MIN_AGE));
`else
      spur      = 1'b0;
`endif
      pop       = hit || timeout;
      full      = (cnt_q == FULL_CNT);
      push      = !clr_i && a_i[ch] && (!full || pop);
      ovf       = !clr_i && a_i[ch] && full && !pop;
      cnt_rem   = pop ? (cnt_q - CW'(1)) : cnt_q;
    end

    // Retire the popped entry, age the survivors and append the new trigger at age 1.
    always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
        shift_src[i] = age_q[i];
      end
      shift_src[DEPTH] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_d[i] = '0;
        if (CW'(i) < cnt_rem) begin
          age_d[i] = (pop ? shift_src[i+1] : shift_src[i]) + AW'(1);
        end else if (push && (CW'(i) == cnt_rem)) begin
          age_d[i] = AW'(1);
        end
      end
      cnt_d = push ? (cnt_rem + CW'(1)) : cnt_rem;
      if (clr_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          age_d[i] = '0;
        end
        cnt_d = '0;
      end
    end

    // Event pulses and saturating counters; fail_cnt can step by two (spur + ovf).
    always_comb begin
      pass_d   = hit;
      fail_d   = timeout;
      spur_d   = spur;
      ovf_d    = ovf;
      bad_inc  = {1'b0, timeout} + {1'b0, spur} + {1'b0, ovf};
      fail_sum = {1'b0, fail_cnt_q} + (CNT_W+1)'(bad_inc);
      if (clr_i) begin
        pass_cnt_d = '0;
        fail_cnt_d = '0;
      end else begin
        pass_cnt_d = (hit && (pass_cnt_q != CNT_MAX)) ? (pass_cnt_q + CNT_W'(1)) : pass_cnt_q;
        fail_cnt_d = fail_sum[CNT_W] ? CNT_MAX : fail_sum[CNT_W-1:0];
      end
    end

    // Per-channel queue, pulse and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          age_q[i] <= '0;
        end
        cnt_q      <= '0;
        pass_q     <= 1'b0;
        fail_q     <= 1'b0;
        spur_q     <= 1'b0;
        ovf_q      <= 1'b0;
        pass_cnt_q <= '0;
        fail_cnt_q <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          age_q[i] <= age_d[i];
        end
        cnt_q      <= cnt_d;
        pass_q     <= pass_d;
        fail_q     <= fail_d;
        spur_q     <= spur_d;
        ovf_q      <= ovf_d;
        pass_cnt_q <= pass_cnt_d;
        fail_cnt_q <= fail_cnt_d;
      end
    end

    assign bad_evt[ch] = timeout | spur | ovf;

    assign pass_o[ch] = pass_q;
    assign fail_o[ch] = fail_q;
    assign spur_o[ch] = spur_q;
    assign ovf_o[ch]  = ovf_q;
    assign pass_cnt_o[ch*CNT_W +: CNT_W] = pass_cnt_q;
    assign fail_cnt_o[ch*CNT_W +: CNT_W] = fail_cnt_q;
  end

  // Sticky error: set by any error event on any channel, cleared only by clr_i or reset.
  always_comb begin
    err_d = err_q;
    if (clr_i) begin
      err_d = 1'b0;
    end else if (|bad_evt) begin
      err_d = 1'b1;
    end
  end

  // Sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_latency_window_checker.sv
// Bench for latency_window_checker: two instances (MIN/MAX = 4/4 and 2/6),
// a hand-computed vector table, hand-written corner sequences, and random
// traffic checked against a timestamp-queue reference model.
`timescale 1ns/1ps
module tb_latency_window_checker;

  localparam int CW = 16;
  localparam int NI = 2;
  localparam int DEPTH = 4;
`ifdef LWC_SPURIOUS_CHECK_EN
  localparam bit SPUR_EN = 1'b1;
`else
  localparam bit SPUR_EN = 1'b0;
`endif

  // event codes {ovf, spur, fail, pass}
  localparam logic [3:0] P = 4'b0001;
  localparam logic [3:0] F = 4'b0010;
  localparam logic [3:0] S = 4'b0100;
  localparam logic [3:0] O = 4'b1000;

  typedef struct {
    logic       a0;
    logic       b0;
    logic [3:0] e0;
    logic       a1;
    logic       b1;
    logic [3:0] e1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [1:0]      a_s [NI];
  logic [1:0]      b_s [NI];
  logic [1:0]      pass_w [NI];
  logic [1:0]      fail_w [NI];
  logic [1:0]      spur_w [NI];
  logic [1:0]      ovf_w [NI];
  logic [2*CW-1:0] pcnt_w [NI];
  logic [2*CW-1:0] fcnt_w [NI];
  logic            err_w [NI];

  always #5 clk = ~clk;

  latency_window_checker #(.CHANNELS(2), .MIN_LAT(4), .MAX_LAT(4), .DEPTH(DEPTH), .CNT_W(CW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .a_i(a_s[0]), .b_i(b_s[0]),
    .pass_o(pass_w[0]), .fail_o(fail_w[0]), .spur_o(spur_w[0]), .ovf_o(ovf_w[0]),
    .pass_cnt_o(pcnt_w[0]), .fail_cnt_o(fcnt_w[0]), .err_o(err_w[0]));

  latency_window_checker #(.CHANNELS(2), .MIN_LAT(2), .MAX_LAT(6), .DEPTH(DEPTH), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .a_i(a_s[1]), .b_i(b_s[1]),
    .pass_o(pass_w[1]), .fail_o(fail_w[1]), .spur_o(spur_w[1]), .ovf_o(ovf_w[1]),
    .pass_cnt_o(pcnt_w[1]), .fail_cnt_o(fcnt_w[1]), .err_o(err_w[1]));

  // ---------------- reference model: queues of trigger edge numbers ----------------
  int         mq [4][$];
  int         edge_n;
  logic [1:0] m_pass [NI];
  logic [1:0] m_fail [NI];
  logic [1:0] m_spur [NI];
  logic [1:0] m_ovf [NI];
  int         m_pcnt [NI][2];
  int         m_fcnt [NI][2];
  logic       m_err [NI];
  int         total;
  int         bad;

  function automatic int min_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int max_of(input int k);
    return (k == 0) ? 4 : 6;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_pass[k] = '0; m_fail[k] = '0; m_spur[k] = '0; m_ovf[k] = '0;
      m_err[k] = 1'b0;
      for (int c = 0; c < 2; c++) begin
        mq[k*2+c].delete();
        m_pcnt[k][c] = 0;
        m_fcnt[k][c] = 0;
      end
    end
  endtask

  task automatic model_edge(input int k);
    int  idx;
    int  age;
    bit  has;
    int  nbad;
    bit  any_bad;
    any_bad = 1'b0;
    m_pass[k] = '0; m_fail[k] = '0; m_spur[k] = '0; m_ovf[k] = '0;
    for (int c = 0; c < 2; c++) begin
      idx = k*2 + c;
      if (clr) begin
        mq[idx].delete();
        m_pcnt[k][c] = 0;
        m_fcnt[k][c] = 0;
      end else begin
        has = (mq[idx].size() > 0);
        age = has ? (edge_n - mq[idx][0]) : 0;
        if (b_s[k][c] && has && age >= min_of(k) && age <= max_of(k)) begin
          m_pass[k][c] = 1'b1;
          void'(mq[idx].pop_front());
        end else if (!b_s[k][c] && has && age == max_of(k)) begin
          m_fail[k][c] = 1'b1;
          void'(mq[idx].pop_front());
        end else if (b_s[k][c] && SPUR_EN) begin
          m_spur[k][c] = 1'b1;
        end
        if (a_s[k][c]) begin
          if (mq[idx].size() < DEPTH) mq[idx].push_back(edge_n);
          else m_ovf[k][c] = 1'b1;
        end
        if (m_pass[k][c]) m_pcnt[k][c] = (m_pcnt[k][c] < 65535) ? m_pcnt[k][c] + 1 : 65535;
        nbad = int'(m_fail[k][c]) + int'(m_spur[k][c]) + int'(m_ovf[k][c]);
        m_fcnt[k][c] = (m_fcnt[k][c] + nbad > 65535) ? 65535 : m_fcnt[k][c] + nbad;
        if (nbad > 0) any_bad = 1'b1;
      end
    end
    if (clr) m_err[k] = 1'b0;
    else if (any_bad) m_err[k] = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("i%0d pass_o", k), 32'(pass_w[k]), 32'(m_pass[k]));
      chk($sformatf("i%0d fail_o", k), 32'(fail_w[k]), 32'(m_fail[k]));
      chk($sformatf("i%0d spur_o", k), 32'(spur_w[k]), 32'(m_spur[k]));
      chk($sformatf("i%0d ovf_o", k), 32'(ovf_w[k]), 32'(m_ovf[k]));
      chk($sformatf("i%0d err_o", k), 32'(err_w[k]), 32'(m_err[k]));
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("i%0d pass_cnt[%0d]", k, c), 32'(pcnt_w[k][c*CW +: CW]), m_pcnt[k][c]);
        chk($sformatf("i%0d fail_cnt[%0d]", k, c), 32'(fcnt_w[k][c*CW +: CW]), m_fcnt[k][c]);
      end
    end
  endtask

  task automatic step(input logic [1:0] a0, input logic [1:0] b0,
                      input logic [1:0] a1, input logic [1:0] b1, input logic c);
    a_s[0] = a0; b_s[0] = b0; a_s[1] = a1; b_s[1] = b1; clr = c;
    @(posedge clk);
    edge_n++;
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s i%0d pulses", tag, k), 32'({ovf_w[k], spur_w[k], fail_w[k], pass_w[k]}), 32'h0);
      chk($sformatf("%s i%0d pass_cnt", tag, k), pcnt_w[k], 32'h0);
      chk($sformatf("%s i%0d fail_cnt", tag, k), fcnt_w[k], 32'h0);
      chk($sformatf("%s i%0d err_o", tag, k), 32'(err_w[k]), 32'h0);
    end
  endtask

  vec_t tbl [32];

  initial begin
    logic [3:0] mask;
    logic [3:0] act;
    total = 0; bad = 0; edge_n = 0;
    for (int k = 0; k < NI; k++) begin a_s[k] = '0; b_s[k] = '0; end
    clr = 1'b0;
    model_reset();

    // Channel-0 vectors for both instances; each row is one edge.
    for (int i = 0; i < 32; i++) tbl[i] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[4]  = '{1'b0, 1'b1, P,    1'b1, 1'b0, O};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, F};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, F};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, F};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, F};
    tbl[10] = '{1'b0, 1'b0, F,    1'b1, 1'b0, 4'h0};
    tbl[11] = '{1'b0, 1'b1, S,    1'b1, 1'b0, 4'h0};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, P};
    tbl[13] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
    tbl[14] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
    tbl[17] = '{1'b0, 1'b1, P,    1'b0, 1'b0, F};
    tbl[18] = '{1'b0, 1'b1, P,    1'b0, 1'b1, S};
    tbl[20] = '{1'b0, 1'b1, S,    1'b1, 1'b0, 4'h0};
    tbl[21] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[22] = '{1'b0, 1'b1, S,    1'b1, 1'b0, 4'h0};
    tbl[23] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[24] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, O};
    tbl[25] = '{1'b0, 1'b1, P,    1'b0, 1'b1, P};
    tbl[26] = '{1'b1, 1'b1, S,    1'b0, 1'b1, P};
    tbl[28] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, F};
    tbl[29] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, F};
    tbl[30] = '{1'b0, 1'b1, P,    1'b0, 1'b0, 4'h0};
    mask = SPUR_EN ? 4'hF : ~S;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 32; i++) begin
      step({1'b0, tbl[i].a0}, {1'b0, tbl[i].b0}, {1'b0, tbl[i].a1}, {1'b0, tbl[i].b1}, 1'b0);
      act = {ovf_w[0][0], spur_w[0][0], fail_w[0][0], pass_w[0][0]};
      chk($sformatf("tbl%0d i0 events", i), 32'(act), 32'(tbl[i].e0 & mask));
      act = {ovf_w[1][0], spur_w[1][0], fail_w[1][0], pass_w[1][0]};
      chk($sformatf("tbl%0d i1 events", i), 32'(act), 32'(tbl[i].e1 & mask));
    end
    chk("tbl i0 pass_cnt", 32'(pcnt_w[0][CW-1:0]), 32'd5);
    chk("tbl i0 fail_cnt", 32'(fcnt_w[0][CW-1:0]), SPUR_EN ? 32'd5 : 32'd1);
    chk("tbl i1 pass_cnt", 32'(pcnt_w[1][CW-1:0]), 32'd3);
    chk("tbl i1 fail_cnt", 32'(fcnt_w[1][CW-1:0]), SPUR_EN ? 32'd10 : 32'd9);
    chk("tbl i0 err", 32'(err_w[0]), 32'd1);
    chk("tbl i0 ch1 untouched", 32'(pcnt_w[0][2*CW-1:CW]) | 32'(fcnt_w[0][2*CW-1:CW]), 32'd0);

    // Per-channel attribution: ch1 alone on instance 0
    step(2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
    repeat (3) step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
    chk("ch1 pass attribution", 32'(pass_w[0]), 32'b10);
    chk("ch1 pass_cnt", 32'(pcnt_w[0][2*CW-1:CW]), 32'd1);

    // Clear with pending triggers and simultaneous a/b: nothing reported
    step(2'b11, 2'b00, 2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b11, 2'b11, 2'b11, 1'b1);
    check_all_zero("clr");
    repeat (7) step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("after clr no fail i0", fcnt_w[0], 32'h0);
    chk("after clr no fail i1", fcnt_w[1], 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      logic [1:0] ra0, rb0, ra1, rb1;
      ra0 = {($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 40)};
      rb0 = {($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30)};
      ra1 = {($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 45)};
      rb1 = {($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 25)};
      step(ra0, rb0, ra1, rb1, ($urandom_range(0, 99) == 0));
    end

    // Reset mid-operation with 3 pending triggers
    repeat (3) step(2'b01, 2'b00, 2'b01, 2'b00, 1'b0);
    for (int k = 0; k < NI; k++) begin a_s[k] = '0; b_s[k] = '0; end
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("post reset no fail i0", fcnt_w[0], 32'h0);
    chk("post reset no fail i1", fcnt_w[1], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
